// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared encodings and sizes for the maze game
package maze_pkg;

    localparam int POS_W   = 9;
    localparam int MAX_NUM = 19;

    // PLAY must remain 2'b10: the mover decodes this value directly.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GEN  = 2'b01,
        ST_PLAY = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - move-clock divider with a commit strobe one clk after the rising edge
module tick_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 10
) (
    input  logic clk,
    input  logic rst_n,
    output logic clk_10Hz,
    output logic commit
);

    localparam int PERIOD = CLK_HZ / TICK_HZ;
    localparam int HALF   = PERIOD / 2;
    localparam int DIV_W  = $clog2(PERIOD);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;

    // Wrap the phase counter at PERIOD-1.
    always_comb begin
        div_next = (div == DIV_W'(PERIOD - 1)) ? '0 : div + 1'b1;
    end

    // Phase counter and registered square wave, high for the first half period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div      <= '0;
            clk_10Hz <= 1'b1;
        end else begin
            div      <= div_next;
            clk_10Hz <= (div_next < DIV_W'(HALF));
        end
    end

    // Mover outputs have had a full clk to settle after the rising edge.
    assign commit = (div == DIV_W'(1));

endmodule

// File: rtl/maze_game_ctrl.sv
// rtl/maze_game_ctrl.sv - game sequencer; optional time limit under MAZE_TIMEOUT_EN
module maze_game_ctrl
    import maze_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_HZ      = 10,
    parameter int MAX_NUM      = maze_pkg::MAX_NUM,
    parameter int TIME_LIMIT_S = 120
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             map_ready,
    input  logic [4:0]       num,
    input  logic [POS_W-1:0] new_x,
    input  logic [POS_W-1:0] new_y,
    input  logic             arrived,
    output logic [1:0]       state,
    output logic             clk_10Hz,
    output logic             gen_req,
    output logic [POS_W-1:0] my_x,
    output logic [POS_W-1:0] my_y,
    output logic [15:0]      steps,
    output logic [7:0]       seconds,
    output logic             timed_out
);

`ifdef MAZE_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    state_t      state_q;
    state_t      state_d;
    logic        gen_req_d;
    logic        commit;
    logic        play_commit;
    logic        enter_play;
    logic        num_ok;
    logic        sec_wrap;
    logic        timeout_hit;
    logic [15:0] sec_tick;
    logic [7:0]  seconds_inc;

    tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_10Hz(clk_10Hz),
        .commit  (commit)
    );

    // Qualify the map size, and precompute the seconds value a commit would produce.
    always_comb begin
        num_ok      = (num != 5'd0) && ({27'd0, num} <= 32'(MAX_NUM));
        sec_wrap    = (sec_tick == 16'(TICK_HZ - 1));
        seconds_inc = (sec_wrap && seconds != 8'hFF) ? seconds + 8'd1 : seconds;
        timeout_hit = TIMEOUT_EN && ({24'd0, seconds_inc} >= 32'(TIME_LIMIT_S));
    end

    // Next-state logic; start beats a commit, arrival beats timeout.
    always_comb begin
        state_d     = state_q;
        gen_req_d   = 1'b0;
        play_commit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    gen_req_d = 1'b1;
                    state_d   = ST_GEN;
                end
            end
            ST_GEN: begin
                if (map_ready && num_ok) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (start) begin
                    gen_req_d = 1'b1;
                    state_d   = ST_GEN;
                end else if (commit) begin
                    if (arrived) begin
                        state_d = ST_DONE;
                    end else begin
                        play_commit = 1'b1;
                        if (timeout_hit) state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    gen_req_d = 1'b1;
                    state_d   = ST_GEN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_play = (state_q == ST_GEN) && (state_d == ST_PLAY);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    assign state = state_q;

    // Position, step and time counters: cleared on PLAY entry, advanced on each commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_req  <= 1'b0;
            my_x     <= '0;
            my_y     <= '0;
            steps    <= '0;
            seconds  <= '0;
            sec_tick <= '0;
        end else begin
            gen_req <= gen_req_d;
            if (enter_play) begin
                my_x     <= '0;
                my_y     <= '0;
                steps    <= '0;
                seconds  <= '0;
                sec_tick <= '0;
            end else if (play_commit) begin
                my_x <= new_x;
                my_y <= new_y;
                if ((new_x != my_x || new_y != my_y) && steps != 16'hFFFF)
                    steps <= steps + 16'd1;
                sec_tick <= sec_wrap ? 16'd0 : sec_tick + 16'd1;
                seconds  <= seconds_inc;
            end
        end
    end

`ifdef MAZE_TIMEOUT_EN
    // Timeout flag, set only by a commit that runs out the clock without arrival.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         timed_out <= 1'b0;
        else if (enter_play)                timed_out <= 1'b0;
        else if (play_commit && timeout_hit) timed_out <= 1'b1;
    end
`else
    assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_maze_game_ctrl.sv
// tb/tb_maze_game_ctrl.sv - directed bench for maze_game_ctrl (P=10, TIME_LIMIT_S=3)
module tb_maze_game_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        map_ready;
    logic [4:0]  num;
    logic [8:0]  new_x;
    logic [8:0]  new_y;
    logic        arrived;
    logic [1:0]  state;
    logic        clk_10Hz;
    logic        gen_req;
    logic [8:0]  my_x;
    logic [8:0]  my_y;
    logic [15:0] steps;
    logic [7:0]  seconds;
    logic        timed_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    maze_game_ctrl #(
        .CLK_HZ      (100),
        .TICK_HZ     (10),
        .MAX_NUM     (19),
        .TIME_LIMIT_S(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .map_ready(map_ready),
        .num      (num),
        .new_x    (new_x),
        .new_y    (new_y),
        .arrived  (arrived),
        .state    (state),
        .clk_10Hz (clk_10Hz),
        .gen_req  (gen_req),
        .my_x     (my_x),
        .my_y     (my_y),
        .steps    (steps),
        .seconds  (seconds),
        .timed_out(timed_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"},   32'(state),     0);
        check({tag, "_clk10"},   32'(clk_10Hz),  1);
        check({tag, "_genreq"},  32'(gen_req),   0);
        check({tag, "_x"},       32'(my_x),      0);
        check({tag, "_y"},       32'(my_y),      0);
        check({tag, "_steps"},   32'(steps),     0);
        check({tag, "_seconds"}, 32'(seconds),   0);
        check({tag, "_timeout"}, 32'(timed_out), 0);
    endtask

    // Returns at the negedge right after clk_10Hz rises (div == 0).
    task automatic sync_rise();
        logic prev;
        bit   found;
        found = 1'b0;
        prev  = clk_10Hz;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (!prev && clk_10Hz) found = 1'b1;
            prev = clk_10Hz;
        end
        if (!found) check("sync_rise_timeout", 0, 1);
    endtask

    // Returns at the negedge just after the next commit edge.
    task automatic wait_commit();
        sync_rise();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic press_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_genreq_hi"}, 32'(gen_req), 1);
        check({tag, "_state_gen"}, 32'(state),   1);
        @(negedge clk);
        check({tag, "_genreq_lo"}, 32'(gen_req), 0);
    endtask

    // Enters PLAY at div==3 so no commit is missed afterwards.
    task automatic enter_play(input string tag, input logic [4:0] n);
        sync_rise();
        @(negedge clk);
        @(negedge clk);
        map_ready = 1'b1;
        num       = n;
        @(negedge clk);
        check({tag, "_state_play"}, 32'(state),   2);
        check({tag, "_x0"},         32'(my_x),    0);
        check({tag, "_y0"},         32'(my_y),    0);
        check({tag, "_steps0"},     32'(steps),   0);
        check({tag, "_seconds0"},   32'(seconds), 0);
        check({tag, "_timeout0"},   32'(timed_out), 0);
    endtask

    initial begin
        bit ok;
        int sec_exp;
        rst_n = 1'b0; start = 1'b0; map_ready = 1'b0; num = 5'd0;
        new_x = '0; new_y = '0; arrived = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;
        @(negedge clk);
        press_start("start1");

        // Illegal sizes keep the sequencer in GEN.
        map_ready = 1'b1;
        num = 5'd0;
        ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (state != 2'b01) ok = 1'b0;
        end
        check("guard_num0", 32'(ok), 1);
        num = 5'd20;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (state != 2'b01) ok = 1'b0;
        end
        check("guard_num20", 32'(ok), 1);
        enter_play("g1", 5'd19);

        // First move, then holding the same position.
        new_x = 9'd1; new_y = 9'd0;
        wait_commit();
        check("move1_x", 32'(my_x), 1);
        check("move1_y", 32'(my_y), 0);
        check("move1_steps", 32'(steps), 1);
        repeat (5) wait_commit();
        check("hold_steps", 32'(steps), 1);
        check("hold_seconds", 32'(seconds), 0);
        repeat (4) wait_commit();
        check("ten_commits_seconds", 32'(seconds), 1);

        // Arrival: position not updated, no timeout.
        new_x = 9'd5; new_y = 9'd5; arrived = 1'b1;
        wait_commit();
        check("arrive_state", 32'(state), 3);
        check("arrive_x", 32'(my_x), 1);
        check("arrive_y", 32'(my_y), 0);
        check("arrive_timeout", 32'(timed_out), 0);
        repeat (20) @(negedge clk);
        check("done_hold_state", 32'(state), 3);
        check("done_hold_steps", 32'(steps), 1);
        arrived = 1'b0; map_ready = 1'b0;
        press_start("restart_done");

        // Second game: seven distinct moves, then asynchronous reset.
        enter_play("g2", 5'd9);
        for (int k = 1; k <= 7; k++) begin
            new_x = 9'(k); new_y = 9'd0;
            wait_commit();
        end
        check("seven_steps", 32'(steps), 7);
        check("seven_x", 32'(my_x), 7);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        new_x = '0; new_y = '0; map_ready = 1'b0;
        @(negedge clk);
        press_start("start3");

        // Third game: 30 commits without arrival.
        enter_play("g3", 5'd5);
        new_x = 9'd2; new_y = 9'd2;
        repeat (30) wait_commit();
        check("t30_seconds", 32'(seconds), 3);
        check("t30_steps", 32'(steps), 1);
`ifdef MAZE_TIMEOUT_EN
        check("t30_state", 32'(state), 3);
        check("t30_timeout", 32'(timed_out), 1);
        sec_exp = 3;
`else
        check("t30_state", 32'(state), 2);
        check("t30_timeout", 32'(timed_out), 0);
        repeat (10) wait_commit();
        check("t40_seconds", 32'(seconds), 4);
        check("t40_state", 32'(state), 2);
        sec_exp = 4;
`endif

        // Start landing on a commit edge: no position update.
        new_x = 9'd3; new_y = 9'd3; map_ready = 1'b0;
        sync_rise();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_commit_state", 32'(state), 1);
        check("start_commit_genreq", 32'(gen_req), 1);
        check("start_commit_x", 32'(my_x), 2);
        check("start_commit_y", 32'(my_y), 2);
        repeat (15) @(negedge clk);
        check("gen_hold_state", 32'(state), 1);
        check("gen_hold_seconds", 32'(seconds), 32'(sec_exp));
        check("gen_hold_genreq", 32'(gen_req), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
